// File: rtl/sum_accumulator_if.sv
// Handshake bundle between an upstream adder, the sum accumulator and the
// downstream consumer of accumulated totals.
interface sum_accumulator_if #(
  parameter int SUM_W = 5,
  parameter int ACC_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic             out_sat;

  // Upstream/downstream environment side
  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_sat
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_sat
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned adder sums into a saturating ACC_W-bit total,
// with a sticky flag recording whether any addition clipped. The result is
// held until the downstream side takes it, during which no input is accepted.
module sum_accumulator #(
  parameter int SUM_W = 5,
  parameter int ACC_W = 6,
  parameter int COUNT = 4
) (
  input logic                clk,
  input logic                rst,
  sum_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Addition width wide enough that neither operand can wrap
  localparam int WW = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
  localparam logic [WW-1:0] MAXV    = WW'({ACC_W{1'b1}});
  localparam logic [7:0]    COUNT_L = 8'(COUNT);

  state_t           state, state_nxt;
  logic             in_rdy, out_vld;
  logic             in_xfer, out_xfer;
  logic [ACC_W-1:0] acc_p0;
  logic             sat_p0;
  logic [7:0]       cnt_p0;
  logic [ACC_W:0]   sum_res;

  // Saturating add: returns {clipped, value}
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    logic [WW-1:0] wide;
    wide = WW'(a) + WW'(b);
    if (wide > MAXV) sat_add = {1'b1, {ACC_W{1'b1}}};
    else             sat_add = {1'b0, wide[ACC_W-1:0]};
  endfunction

  assign in_xfer  = bus.in_valid && in_rdy;
  assign out_xfer = out_vld && bus.out_ready;

  // A fresh result starts from zero; later samples build on the running total
  assign sum_res = sat_add((state == IDLE) ? '0 : acc_p0, bus.in_sum);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = (COUNT_L == 8'd1) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_rdy = 1'b1;
        if (bus.in_valid && (cnt_p0 == COUNT_L - 8'd1)) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Running total, sample count and sticky saturation flag
  always_ff @(posedge clk) begin
    if (rst || out_xfer) begin
      acc_p0 <= '0;
      sat_p0 <= 1'b0;
      cnt_p0 <= '0;
    end else if (in_xfer) begin
      acc_p0 <= sum_res[ACC_W-1:0];
      if (state == IDLE) begin
        sat_p0 <= sum_res[ACC_W];
        cnt_p0 <= 8'd1;
      end else begin
        sat_p0 <= sat_p0 | sum_res[ACC_W];
        cnt_p0 <= cnt_p0 + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_total = acc_p0;
  assign bus.out_sat   = sat_p0;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sum_accumulator_if #(.SUM_W(5), .ACC_W(6)) bus  ();
  sum_accumulator_if #(.SUM_W(5), .ACC_W(6)) bus1 ();

  sum_accumulator #(.SUM_W(5), .ACC_W(6), .COUNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sum_accumulator #(.SUM_W(5), .ACC_W(6), .COUNT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] exp_q[$];   // {sat, total}

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        check("result_total", int'(bus.out_total), int'(e[5:0]));
        check("result_sat",   int'(bus.out_sat),   int'(e[6]));
      end
    end
  end

  task automatic send(input logic [4:0] s);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input int total, input int sat);
    exp_q.push_back({sat[0], total[5:0]});
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_sum = '0;  bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_sum = '0; bus1.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_total",     int'(bus.out_total), 0);
    check("rst_sat",       int'(bus.out_sat),   0);

    // Nominal run 0,3,8,16 -> 27
    expect_res(27, 0);
    send(5'd0); send(5'd3); send(5'd8); send(5'd16);
    check("nom_valid", int'(bus.out_valid), 1);
    check("nom_total", int'(bus.out_total), 27);
    tick();
    check("nom_valid_one_cycle", int'(bus.out_valid), 0);
    check("nom_in_ready_after",  int'(bus.in_ready),  1);

    // Saturation run, then a clean run proving the flag clears
    expect_res(63, 1);
    send(5'd31); send(5'd31); send(5'd2); send(5'd0);
    expect_res(4, 0);
    send(5'd1); send(5'd1); send(5'd1); send(5'd1);

    // Gaps: total must hold while in_valid is low
    expect_res(32, 0);
    send(5'd15); tick(); tick();
    check("gap1_total", int'(bus.out_total), 15);
    send(5'd15); tick(); tick();
    check("gap2_total", int'(bus.out_total), 30);
    send(5'd1);  tick(); tick();
    check("gap3_total", int'(bus.out_total), 31);
    send(5'd1);
    tick();

    // Backpressure with a held input that must wait for the drain
    bus.out_ready = 1'b0;
    expect_res(27, 0);
    send(5'd0); send(5'd3); send(5'd8); send(5'd16);
    bus.in_valid = 1'b1; bus.in_sum = 5'd31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  int'(bus.in_ready),  0);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_total",     int'(bus.out_total), 27);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    tick();
    check("bp_drained_total", int'(bus.out_total), 0);
    check("bp_drained_ready", int'(bus.in_ready),  1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_held_accepted", int'(bus.out_total), 31);
    expect_res(31, 0);
    send(5'd0); send(5'd0); send(5'd0);
    tick();

    // Mid-operation reset discards the partial result
    send(5'd8); send(5'd8);
    check("mid_partial", int'(bus.out_total), 16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_total", int'(bus.out_total), 0);
    check("mid_rst_ready", int'(bus.in_ready),  1);
    check("mid_rst_valid", int'(bus.out_valid), 0);
    expect_res(10, 0);
    send(5'd1); send(5'd2); send(5'd3); send(5'd4);
    tick();

    // COUNT=1 instance
    bus1.in_valid = 1'b1; bus1.in_sum = 5'd16;
    tick();
    bus1.in_valid = 1'b0;
    check("c1_valid", int'(bus1.out_valid), 1);
    check("c1_total", int'(bus1.out_total), 16);
    check("c1_ready", int'(bus1.in_ready),  0);
    bus1.out_ready = 1'b1;
    tick();
    check("c1_drained", int'(bus1.out_valid), 0);

    // Every expected result must have been observed
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
